// File: rtl/sp_arbiter.sv
// sp_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one single-port block RAM (2048x8 SP primitive) between two
//   independent clients. At most one access is granted per cycle. When both
//   clients request in the same cycle, the one not granted last time wins.
//   The granted request drives the SP port directly. A small tag pipe tracks
//   which client issued each read, so the read data can be routed back to it.
//
// Handshake:
//   A request is accepted at a rising edge where reqN_valid & reqN_ready.
//   reqN_ready is a pure function of the current valids and the round-robin
//   pointer, and it never asserts without reqN_valid. Responses have no
//   backpressure: rspN_valid is high for exactly one cycle, LAT cycles after
//   the read was accepted, and the client must take the data then.
//
// Configuration macro:
//   SP_ARBITER_OUTREG_EN - defined: the SP runs with its output register
//                          (READ_MODE=1), so LAT = 2.
//                          undefined: bypass mode (READ_MODE=0), LAT = 1.
//
// Ports:
//   clock, reset                : clock; asynchronous active-high reset
//   req{0,1}_valid/_write/_addr/_wdata : request inputs from each client
//   req{0,1}_ready              : request accepted this cycle
//   rsp{0,1}_valid/_rdata       : read response (rdata is 0 when not valid)
//   mem_ce, mem_wre, mem_ad,
//   mem_din, mem_oce            : SP primitive control/address/data
//   mem_dout                    : SP read data
// ----------------------------------------------------------------------------
module sp_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  mem_ce,
  output logic                  mem_wre,
  output logic [ADDR_WIDTH-1:0] mem_ad,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_oce,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

`ifdef SP_ARBITER_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // Round-robin pointer: index of the requester granted most recently.
  // Resets to 1 so requester 0 wins the first contested cycle.
  logic last_grant_q, last_grant_d;

  // Read tag pipe: entry 0 is loaded at acceptance, entry LAT-1 is the
  // response currently being presented.
  logic [LAT-1:0] tag_v_q,  tag_v_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;

  logic grant0, grant1;
  logic rd_accept;

  // Grant. Reset forces both grants low so nothing reaches the RAM and no
  // requester sees ready while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant0 = req0_valid & (~req1_valid | last_grant_q);
      grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // SP drive, zeroed when idle.
  always_comb begin
    mem_ce  = grant0 | grant1;
    mem_wre = 1'b0;
    mem_ad  = '0;
    mem_din = '0;
    if (grant0) begin
      mem_wre = req0_write;
      mem_ad  = req0_addr;
      mem_din = req0_wdata;
    end else if (grant1) begin
      mem_wre = req1_write;
      mem_ad  = req1_addr;
      mem_din = req1_wdata;
    end
  end

  assign mem_oce = 1'b1;

  assign rd_accept = mem_ce & ~mem_wre;

  // Next-state: pointer follows the granted index; tag pipe shifts every
  // cycle, with writes and idle cycles entering as empty slots.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0) begin
      last_grant_d = 1'b0;
    end else if (grant1) begin
      last_grant_d = 1'b1;
    end

    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = rd_accept;
    tag_id_d[0] = grant1;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
    end
  end

  // Response routing from the head of the tag pipe.
  always_comb begin
    rsp0_valid = tag_v_q[LAT-1] & ~tag_id_q[LAT-1];
    rsp1_valid = tag_v_q[LAT-1] &  tag_id_q[LAT-1];
    rsp0_rdata = rsp0_valid ? mem_dout : '0;
    rsp1_rdata = rsp1_valid ? mem_dout : '0;
  end

endmodule

// File: tb/tb_sp_arbiter.sv
// Testbench for sp_arbiter. Contains a behavioural model of the external SP
// RAM (write-first, optional output register) and a reference memory plus
// round-robin model that produce every expected value.
module tb_sp_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
`ifdef SP_ARBITER_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  // Scoreboard entry: {due cycle, requester id, data}
  localparam int EW = 32 + 1 + DW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          req0_valid, req0_ready, req0_write;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic          mem_ce, mem_wre, mem_oce;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_din, mem_dout;

  sp_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_ad(mem_ad), .mem_din(mem_din),
    .mem_oce(mem_oce), .mem_dout(mem_dout)
  );

  // ---------------- SP RAM model ----------------
  logic [DW-1:0] ram [2048];
  logic [DW-1:0] ram_dout_r, ram_dout_r2;
  always @(posedge clock) begin
    if (mem_ce) begin
      if (mem_wre) begin
        ram[mem_ad] <= mem_din;
        ram_dout_r  <= mem_din;
      end else begin
        ram_dout_r  <= ram[mem_ad];
      end
    end
  end
  always @(posedge clock) begin
    if (mem_oce) ram_dout_r2 <= ram_dout_r;
  end
`ifdef SP_ARBITER_OUTREG_EN
  assign mem_dout = ram_dout_r2;
`else
  assign mem_dout = ram_dout_r;
`endif

  // ---------------- scoreboard / reference ----------------
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [2048];
  logic          exp_last;
  int            cyc;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Checks the response ports against the head of the scoreboard.
  task automatic sample_rsp();
    logic [EW-1:0] e;
    if (rsp0_valid && rsp1_valid) check("rsp_both_valid", 32'd1, 32'd0);
    if (!rsp0_valid) check("rsp0_rdata_idle", 32'(rsp0_rdata), 32'd0);
    if (!rsp1_valid) check("rsp1_rdata_idle", 32'(rsp1_rdata), 32'd0);
    if (rsp0_valid || rsp1_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", {31'd0, rsp1_valid}, {31'd0, e[DW]});
        check("rsp_data", rsp1_valid ? 32'(rsp1_rdata) : 32'(rsp0_rdata), 32'(e[DW-1:0]));
        check("rsp_latency", 32'(cyc), e[EW-1:DW+1]);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q[0];
      if (int'(e[EW-1:DW+1]) <= cyc) begin
        check("rsp_missing", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  endtask

  // One clock cycle: drive, sample at the falling edge, update the model,
  // then move to just after the next rising edge.
  task automatic step(input logic v0, input logic w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input logic v1, input logic w1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic e0, e1;
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
    @(negedge clock);
    cyc++;
    sample_rsp();
    e0 = v0 && (!v1 || exp_last);
    e1 = v1 && !e0;
    check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    check("mem_ce", {31'd0, mem_ce}, {31'd0, e0 | e1});
    check("mem_wre", {31'd0, mem_wre}, {31'd0, (e0 & w0) | (e1 & w1)});
    check("mem_ad", 32'(mem_ad), e0 ? 32'(a0) : (e1 ? 32'(a1) : 32'd0));
    check("mem_din", 32'(mem_din), e0 ? 32'(d0) : (e1 ? 32'(d1) : 32'd0));
    check("mem_oce", {31'd0, mem_oce}, 32'd1);
    if (e0 || e1) begin
      exp_last = e1;
      if (e0 && w0) ref_mem[a0] = d0;
      else if (e1 && w1) ref_mem[a1] = d1;
      else exp_q.push_back({32'(cyc + LAT), e1, e0 ? ref_mem[a0] : ref_mem[a1]});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Asserts reset asynchronously with both requesters valid and checks the
  // immediate effects, then releases it just after a rising edge.
  task automatic apply_reset();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 11'd3;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 11'd4;
    #1;
    reset = 1'b1;
    #1;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
    check("rst_rsp1_rdata", 32'(rsp1_rdata), 32'd0);
    exp_q.delete();
    exp_last = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; exp_last = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    @(posedge clock);
    #1;
    apply_reset();

    // Single requester: write the whole RAM then read it back.
    for (int a = 0; a < 2048; a++) step(1, 1, 11'(a), 8'(a), 0, 0, '0, '0);
    for (int a = 0; a < 2048; a++) step(1, 0, 11'(a), '0, 0, 0, '0, '0);
    idle(LAT + 1);

    // Contention: continuous reads from both, alternation starting with 0.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) check("contend_first_grant_model", {31'd0, exp_last}, 32'd1);
      step(1, 0, 11'd5, '0, 1, 0, 11'd9, '0);
    end
    idle(LAT + 1);

    // Mixed: req0 write vs req1 read of the same address, then re-read.
    step(1, 1, 11'd100, 8'hA5, 1, 0, 11'd100, '0);
    step(0, 0, '0, '0, 1, 0, 11'd100, '0);
    idle(LAT + 1);

    // Reset mid-read: the in-flight response must be dropped.
    step(1, 0, 11'd7, '0, 0, 0, '0, '0);
    apply_reset();
    idle(LAT + 2);
    step(1, 0, 11'd20, '0, 1, 0, 11'd21, '0);
    idle(LAT + 1);

    // Idle/fairness: req1 alone, an idle cycle, then contention.
    apply_reset();
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 1, 0, 11'(30 + i), '0);
    idle(1);
    step(1, 0, 11'd40, '0, 1, 0, 11'd41, '0);
    step(1, 0, 11'd42, '0, 1, 0, 11'd43, '0);
    idle(LAT + 1);

    // Random mixed traffic over a small address window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)));
    end
    idle(LAT + 2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
